sdram_wr_burst_feeder: RTL
==========================

Name: sdram_wr_burst_feeder

Overview:
- Write-side front end sitting directly upstream of sdram_top.
- Accepts single 16-bit words from a client (CPU/DMA) at up to one per clk_50m cycle and buffers them in a FIFO.
- Packs buffered words into bursts and drives sdram_top's write request port: sdram_wr_req, sdram_wr_addr, sdwr_bytes, sdram_wr_data, sdram_wr_ack.
- Auto-increments the SDRAM word address across bursts, so the client sees a plain streaming write port.

Parameters:
- FIFO_AW, 9: FIFO depth = 2^FIFO_AW words (512).
- BURST_LEN, 8: words per full burst; range 1..256, must be ≤ 2^FIFO_AW.
- BASE_ADDR, 24'h000000: write address after reset.

Ports:
- clk_50m  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  client push strobe
- wr_data  in  16  client word
- wr_full  out  1  FIFO full; a push while high is dropped
- addr_load  in  1  load new start address
- addr_in  in  24  start address for addr_load
- flush  in  1  pulse: emit remaining words even if fewer than BURST_LEN
- level  out  FIFO_AW+1  words currently buffered
- overflow  out  1  sticky; set by a dropped push, cleared only by reset
- sdram_init_done  in  1  from sdram_top
- sdram_busy  in  1  from sdram_top
- sdram_wr_req  out  1  burst request
- sdram_wr_addr  out  24  burst start address, {bank[1:0], row[12:0], col[8:0]}
- sdwr_bytes  out  9  words in this burst (1..BURST_LEN)
- sdram_wr_data  out  16  current burst word (FIFO head)
- sdram_wr_ack  in  1  high for each cycle sdram_top consumes one word

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except sdram_wr_addr=BASE_ADDR; FIFO emptied; state IDLE; flush_pending=0; overflow=0.
- FIFO: first-word-fall-through.
  - sdram_wr_data equals the head word combinationally.
  - Pop occurs on every cycle with sdram_wr_ack=1 while in state XFER or REQ.
  - Push on wr_en && !wr_full.
  - Push and pop in the same cycle: level unchanged; push when full and pop same cycle is still dropped (wr_full is registered).
  - wr_full = (level == 2^FIFO_AW).
- flush: sets flush_pending; cleared when a burst launched while flush_pending drains the FIFO to 0, or when level is already 0 in IDLE.
- State machine:
  - IDLE: when sdram_init_done && !sdram_busy && (level ≥ BURST_LEN || (flush_pending && level > 0)), latch n = min(level, BURST_LEN), then go to REQ next cycle. sdwr_bytes = n and sdram_wr_addr = cur_addr are registered in this transition.
  - REQ: sdram_wr_req=1, held until the first sdram_wr_ack. That ack cycle pops word 0 (cnt=1). Then go to XFER, deasserting sdram_wr_req the next cycle.
  - XFER: each ack pops one word and increments cnt. A gap in ack (ack=0) stalls without error. When cnt reaches n, go to DONE.
  - DONE (1 cycle): cur_addr += n (mod 2^24, wraps 24'hFFFFFF→0). Go to IDLE.
- sdwr_bytes, sdram_wr_addr stable from REQ entry until DONE.
- sdram_wr_ack in IDLE/DONE is ignored; no pop occurs.
- Words pushed during a burst are never included in it: n is frozen at launch.
- addr_load:
  - In IDLE, cur_addr = addr_in next cycle.
  - In any other state it is held pending and applied in DONE instead of the increment.
  - A later addr_load overwrites a pending one.
- Latency: with init_done=1, busy=0, the push of the BURST_LEN-th word at cycle t gives level update at t+1, IDLE decision at t+1, and sdram_wr_req=1 at t+2.
- Reset mid-burst: burst abandoned, FIFO contents lost, sdram_wr_req drops asynchronously.
- sdram_init_done=0: remain in IDLE indefinitely; pushes still accepted.

Decomposition:
- Shared package sdram_pkg:
  - SDRAM_AW=24, SDRAM_DW=16, SDRAM_LENW=9.
  - Feeder state encoding IDLE/REQ/XFER/DONE.
  - Address field widths: bank 2, row 13, col 9.
- One sub-module: sdram_sync_fifo (parameters DW, AW; FWFT; ports push/pop/din/dout/level/full/empty). Reused later by the read-side drain block.

Test Plan:
- Reset, init_done=1, push 8 words 16'h0001..0008; ack asserted 8 consecutive cycles starting 2 cycles after req → sdram_wr_req=1 with addr=0, sdwr_bytes=8; data 0001..0008 in order; next burst addr=24'h000008.
- Push 3 words, pulse flush → one burst with sdwr_bytes=3; level returns to 0; flush_pending cleared.
- Fill 512 words with ack held 0 and busy=1, push 1 more → wr_full=1; extra word dropped; overflow=1 stays set after drain; level=512.
- addr_load 24'hFFFFFC in IDLE, push 8, complete burst → burst addr=FFFFFC; cur_addr wraps to 24'h000004.
- Ack with gaps (1,0,1,1,0,…) during an 8-word burst → exactly 8 pops, data order intact, no req re-assertion until DONE.
- Assert rst_n=0 during XFER after 4 acks → all outputs reset immediately; after release, level=0 and sdram_wr_addr=BASE_ADDR.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM types and widths.
// Used by the write feeder, its FIFO and the read-side drain.
package sdram_pkg;

  localparam int SDRAM_AW   = 24;
  localparam int SDRAM_DW   = 16;
  localparam int SDRAM_LENW = 9;

  localparam int BANK_W = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 9;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } feed_st_t;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } sdram_addr_t;

endpackage

// File: rtl/sdram_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports: push/din in, pop in, dout = head word, level/full/empty out.
module sdram_sync_fifo #(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;
  localparam int LW    = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_level == LW'(DEPTH));
  assign empty  = (r_level == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rp];
  assign level  = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)
        r_level <= r_level + LW'(1);
      else if (w_pop && !w_push)
        r_level <= r_level - LW'(1);
    end
  end

endmodule

// File: rtl/sdram_wr_burst_feeder.sv
// Buffers client words and feeds them to sdram_top as write bursts.
// Client: wr_en/wr_data/wr_full, addr_load/addr_in, flush; SDRAM: req/addr/bytes/data/ack.
module sdram_wr_burst_feeder
  import sdram_pkg::*;
#(
  parameter int                  FIFO_AW   = 9,
  parameter int                  BURST_LEN = 8,
  parameter logic [SDRAM_AW-1:0] BASE_ADDR = 24'h000000
) (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [SDRAM_DW-1:0]   wr_data,
  output logic                  wr_full,
  input  logic                  addr_load,
  input  logic [SDRAM_AW-1:0]   addr_in,
  input  logic                  flush,
  output logic [FIFO_AW:0]      level,
  output logic                  overflow,
  input  logic                  sdram_init_done,
  input  logic                  sdram_busy,
  output logic                  sdram_wr_req,
  output logic [SDRAM_AW-1:0]   sdram_wr_addr,
  output logic [SDRAM_LENW-1:0] sdwr_bytes,
  output logic [SDRAM_DW-1:0]   sdram_wr_data,
  input  logic                  sdram_wr_ack
);

  localparam int LVW = FIFO_AW + 1;

  feed_st_t              r_state;
  logic [SDRAM_LENW-1:0] r_n;
  logic [SDRAM_LENW-1:0] r_cnt;
  logic [SDRAM_AW-1:0]   r_cur_addr;
  logic [SDRAM_AW-1:0]   r_pend_addr;
  logic                  r_pend;
  logic                  r_flush_pend;
  logic                  r_burst_flush;
  logic                  r_req;
  logic [SDRAM_AW-1:0]   r_wr_addr;
  logic [SDRAM_LENW-1:0] r_bytes;
  logic                  r_overflow;

  logic [SDRAM_DW-1:0]   w_head;
  logic [LVW-1:0]        w_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_big;
  logic                  w_go;
  logic [SDRAM_LENW-1:0] w_n;

  sdram_sync_fifo #(
    .DW(SDRAM_DW),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk  (clk_50m),
    .rst_n(rst_n),
    .push (wr_en),
    .pop  (w_pop),
    .din  (wr_data),
    .dout (w_head),
    .level(w_level),
    .full (w_full),
    .empty(w_empty)
  );

  assign w_pop = sdram_wr_ack &&
                 (r_state == REQ || r_state == XFER);
  assign w_big = (w_level >= LVW'(BURST_LEN));
  assign w_go  = sdram_init_done && !sdram_busy &&
                 (w_big || (r_flush_pend && !w_empty));
  assign w_n   = w_big ? SDRAM_LENW'(BURST_LEN)
                       : SDRAM_LENW'(w_level);

  assign wr_full       = w_full;
  assign level         = w_level;
  assign overflow      = r_overflow;
  assign sdram_wr_req  = r_req;
  assign sdram_wr_addr = r_wr_addr;
  assign sdwr_bytes    = r_bytes;
  // Mask stale RAM contents so an empty FIFO shows zero.
  assign sdram_wr_data = w_empty ? '0 : w_head;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_n           <= '0;
      r_cnt         <= '0;
      r_cur_addr    <= BASE_ADDR;
      r_pend_addr   <= '0;
      r_pend        <= 1'b0;
      r_flush_pend  <= 1'b0;
      r_burst_flush <= 1'b0;
      r_req         <= 1'b0;
      r_wr_addr     <= BASE_ADDR;
      r_bytes       <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (wr_en && w_full) r_overflow <= 1'b1;

      if (flush)
        r_flush_pend <= 1'b1;
      else if (r_state == IDLE && w_empty)
        r_flush_pend <= 1'b0;
      else if (r_state == DONE && r_burst_flush && w_empty)
        r_flush_pend <= 1'b0;

      unique case (r_state)
        IDLE: begin
          // A load coinciding with launch must survive the DONE increment.
          if (addr_load && !w_go) r_cur_addr <= addr_in;
          if (addr_load && w_go) begin
            r_pend      <= 1'b1;
            r_pend_addr <= addr_in;
          end
          if (w_go) begin
            r_state       <= REQ;
            r_n           <= w_n;
            r_bytes       <= w_n;
            r_wr_addr     <= r_cur_addr;
            r_req         <= 1'b1;
            r_cnt         <= '0;
            r_burst_flush <= r_flush_pend;
          end
        end
        REQ: begin
          if (addr_load) begin
            r_pend      <= 1'b1;
            r_pend_addr <= addr_in;
          end
          if (sdram_wr_ack) begin
            r_req   <= 1'b0;
            r_cnt   <= SDRAM_LENW'(1);
            // Single-word bursts are finished by the request ack.
            r_state <= (r_n == SDRAM_LENW'(1)) ? DONE : XFER;
          end
        end
        XFER: begin
          if (addr_load) begin
            r_pend      <= 1'b1;
            r_pend_addr <= addr_in;
          end
          if (sdram_wr_ack) begin
            r_cnt <= r_cnt + SDRAM_LENW'(1);
            if (r_cnt + SDRAM_LENW'(1) == r_n) r_state <= DONE;
          end
        end
        DONE: begin
          if (addr_load)
            r_cur_addr <= addr_in;
          else if (r_pend)
            r_cur_addr <= r_pend_addr;
          else
            r_cur_addr <= r_cur_addr + SDRAM_AW'(r_n);
          r_pend  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
